// File: rtl/msg_header_parser.sv
// Receive-side message header parser: hunts for the 0x1234 sync word, decodes the
// 8-byte little-endian header, then streams the payload with completion/error strobes.
module msg_header_parser #(
  parameter logic [15:0] MaxByteCount  = 16'h100,
  parameter logic [23:0] TimeoutClocks = 24'd1_000_000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  InByte,
  input  logic        InByteReady,
  output logic [15:0] MsgByteCount,
  output logic [15:0] MsgID,
  output logic [15:0] SequenceNumber,
  output logic        HeaderValid,
  output logic [7:0]  DataByte,
  output logic        DataByteReady,
  output logic        MsgComplete,
  output logic        MsgError,
  output logic        Busy
);

  typedef enum logic [3:0] {
    Sync0, Sync1, Count0, Count1, Id0, Id1, Seq0, Seq1, Data
  } state_t;

  state_t      stateReg, stateNext;
  logic [15:0] countReg, countNext;
  logic [15:0] idReg, idNext;
  logic [7:0]  seqLoReg, seqLoNext;
  logic [15:0] remainingReg, remainingNext;
  logic [23:0] timeoutReg, timeoutNext;

  logic [15:0] msgByteCountNext, msgIdNext, sequenceNumberNext;
  logic [7:0]  dataByteNext;
  logic        headerValidNext, dataByteReadyNext, msgCompleteNext, msgErrorNext;
  logic        busyNext;

  logic        timeoutHit;
  logic [15:0] countAssembled;

  assign timeoutHit     = (stateReg != Sync0) && (timeoutReg == TimeoutClocks);
  assign countAssembled = {InByte, countReg[7:0]};

  always_comb begin
    stateNext          = stateReg;
    countNext          = countReg;
    idNext             = idReg;
    seqLoNext          = seqLoReg;
    remainingNext      = remainingReg;
    msgByteCountNext   = MsgByteCount;
    msgIdNext          = MsgID;
    sequenceNumberNext = SequenceNumber;
    dataByteNext       = DataByte;
    headerValidNext    = 1'b0;
    dataByteReadyNext  = 1'b0;
    msgCompleteNext    = 1'b0;
    msgErrorNext       = 1'b0;

    // An expired timeout wins over a byte arriving on the same cycle.
    if (timeoutHit) begin
      msgErrorNext = 1'b1;
      stateNext    = Sync0;
    end else if (InByteReady) begin
      unique case (stateReg)
        Sync0: if (InByte == 8'h34) stateNext = Sync1;
        Sync1: begin
          if (InByte == 8'h12)      stateNext = Count0;
          else if (InByte != 8'h34) stateNext = Sync0;
        end
        Count0: begin
          countNext = {8'h00, InByte};
          stateNext = Count1;
        end
        Count1: begin
          countNext = countAssembled;
          if (countAssembled < 16'd8 || countAssembled > MaxByteCount) begin
            msgErrorNext = 1'b1;
            stateNext    = Sync0;
          end else begin
            stateNext = Id0;
          end
        end
        Id0: begin
          idNext    = {8'h00, InByte};
          stateNext = Id1;
        end
        Id1: begin
          idNext    = {InByte, idReg[7:0]};
          stateNext = Seq0;
        end
        Seq0: begin
          seqLoNext = InByte;
          stateNext = Seq1;
        end
        Seq1: begin
          msgByteCountNext   = countReg;
          msgIdNext          = idReg;
          sequenceNumberNext = {InByte, seqLoReg};
          headerValidNext    = 1'b1;
          remainingNext      = countReg - 16'd8;
          if (countReg == 16'd8) begin
            msgCompleteNext = 1'b1;
            stateNext       = Sync0;
          end else begin
            stateNext = Data;
          end
        end
        Data: begin
          dataByteNext      = InByte;
          dataByteReadyNext = 1'b1;
          remainingNext     = remainingReg - 16'd1;
          if (remainingReg == 16'd1) begin
            msgCompleteNext = 1'b1;
            stateNext       = Sync0;
          end
        end
        default: stateNext = Sync0;
      endcase
    end

    if (InByteReady || stateReg == Sync0 || timeoutHit) timeoutNext = 24'd0;
    else                                               timeoutNext = timeoutReg + 24'd1;

    busyNext = (stateNext != Sync0);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      stateReg       <= Sync0;
      countReg       <= 16'h0;
      idReg          <= 16'h0;
      seqLoReg       <= 8'h0;
      remainingReg   <= 16'h0;
      timeoutReg     <= 24'h0;
      MsgByteCount   <= 16'h0;
      MsgID          <= 16'h0;
      SequenceNumber <= 16'h0;
      DataByte       <= 8'h0;
      HeaderValid    <= 1'b0;
      DataByteReady  <= 1'b0;
      MsgComplete    <= 1'b0;
      MsgError       <= 1'b0;
      Busy           <= 1'b0;
    end else begin
      stateReg       <= stateNext;
      countReg       <= countNext;
      idReg          <= idNext;
      seqLoReg       <= seqLoNext;
      remainingReg   <= remainingNext;
      timeoutReg     <= timeoutNext;
      MsgByteCount   <= msgByteCountNext;
      MsgID          <= msgIdNext;
      SequenceNumber <= sequenceNumberNext;
      DataByte       <= dataByteNext;
      HeaderValid    <= headerValidNext;
      DataByteReady  <= dataByteReadyNext;
      MsgComplete    <= msgCompleteNext;
      MsgError       <= msgErrorNext;
      Busy           <= busyNext;
    end
  end

endmodule

// File: tb/tb_msg_header_parser.sv
// Bench for msg_header_parser: directed and random byte streams compared every cycle
// against a byte-position reference model of the message format.
module tb_msg_header_parser;

  localparam logic [15:0] MaxCnt = 16'h100;
  localparam int          ToClk  = 16;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [7:0]  InByte = 8'h00;
  logic        InByteReady = 1'b0;
  logic [15:0] MsgByteCount, MsgID, SequenceNumber;
  logic        HeaderValid, DataByteReady, MsgComplete, MsgError, Busy;
  logic [7:0]  DataByte;

  msg_header_parser #(.MaxByteCount(MaxCnt), .TimeoutClocks(24'(ToClk))) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InByte(InByte), .InByteReady(InByteReady),
    .MsgByteCount(MsgByteCount), .MsgID(MsgID), .SequenceNumber(SequenceNumber),
    .HeaderValid(HeaderValid), .DataByte(DataByte), .DataByteReady(DataByteReady),
    .MsgComplete(MsgComplete), .MsgError(MsgError), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference model: position within the current message, header bytes by index.
  int         pos = 0;
  int         idle = 0;
  logic [7:0] hdr [0:7];
  int         cnt = 0;
  logic [15:0] eCount = 0, eId = 0, eSeq = 0;
  logic [7:0]  eData = 0;
  logic        eHV = 0, eDR = 0, eMC = 0, eME = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelEdge(input logic rst_n, input logic v, input logic [7:0] b);
    eHV = 0; eDR = 0; eMC = 0; eME = 0;
    if (!rst_n) begin
      pos = 0; idle = 0; eCount = 0; eId = 0; eSeq = 0; eData = 0;
    end else if (pos != 0 && idle == ToClk) begin
      eME = 1; pos = 0; idle = 0;
    end else if (v) begin
      idle = 0;
      if (pos == 0) begin
        if (b == 8'h34) pos = 1;
      end else if (pos == 1) begin
        pos = (b == 8'h12) ? 2 : (b == 8'h34) ? 1 : 0;
      end else if (pos < 8) begin
        hdr[pos] = b;
        if (pos == 3) begin
          cnt = int'(b) * 256 + int'(hdr[2]);
          if (cnt < 8 || cnt > int'(MaxCnt)) begin eME = 1; pos = 0; end
          else pos = 4;
        end else if (pos == 7) begin
          eCount = 16'(cnt);
          eId    = {hdr[5], hdr[4]};
          eSeq   = {hdr[7], hdr[6]};
          eHV    = 1;
          if (cnt == 8) begin eMC = 1; pos = 0; end
          else pos = 8;
        end else begin
          pos++;
        end
      end else begin
        eData = b; eDR = 1; pos++;
        if (pos == cnt) begin eMC = 1; pos = 0; end
      end
    end else if (pos != 0) begin
      idle++;
    end else begin
      idle = 0;
    end
  endtask

  task automatic step(input logic rst_n, input logic v, input logic [7:0] b);
    @(negedge Clk);
    Reset_n = rst_n; InByteReady = v; InByte = b;
    @(posedge Clk);
    modelEdge(rst_n, v, b);
    #1;
    chk("MsgByteCount", MsgByteCount, eCount);
    chk("MsgID", MsgID, eId);
    chk("SequenceNumber", SequenceNumber, eSeq);
    chk("DataByte", {8'h0, DataByte}, {8'h0, eData});
    chk("HeaderValid", {15'h0, HeaderValid}, {15'h0, eHV});
    chk("DataByteReady", {15'h0, DataByteReady}, {15'h0, eDR});
    chk("MsgComplete", {15'h0, MsgComplete}, {15'h0, eMC});
    chk("MsgError", {15'h0, MsgError}, {15'h0, eME});
    chk("Busy", {15'h0, Busy}, {15'h0, logic'(pos != 0)});
  endtask

  task automatic sendByte(input logic [7:0] b, input int maxGap);
    int gap;
    gap = (maxGap > 0) ? int'($urandom_range(maxGap)) : 0;
    for (int i = 0; i < gap; i++) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, b);
  endtask

  task automatic sendMsg(input logic [15:0] count, input logic [15:0] id,
                         input logic [15:0] seq, input int maxGap);
    sendByte(8'h34, maxGap); sendByte(8'h12, maxGap);
    sendByte(count[7:0], maxGap); sendByte(count[15:8], maxGap);
    sendByte(id[7:0], maxGap); sendByte(id[15:8], maxGap);
    sendByte(seq[7:0], maxGap); sendByte(seq[15:8], maxGap);
    for (int i = 8; i < int'(count); i++) sendByte(8'($urandom), maxGap);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] demo [0:11];
    demo = '{8'h34, 8'h12, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h07, 8'h00,
             8'hAA, 8'hBB, 8'hCC, 8'hDD};

    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    idleCycles(2);

    // 12-byte message with random gaps.
    for (int i = 0; i < 12; i++) sendByte(demo[i], 3);
    idleCycles(2);
    chk("demo_count", MsgByteCount, 16'd12);
    chk("demo_id", MsgID, 16'd5);
    chk("demo_seq", SequenceNumber, 16'd7);
    chk("demo_lastdata", {8'h0, DataByte}, 16'h00DD);

    // 8-byte header-only message back-to-back.
    sendMsg(16'd8, 16'd2, 16'hFFFF, 0);
    idleCycles(1);
    chk("short_seq", SequenceNumber, 16'hFFFF);

    // Leading garbage, repeated sync byte, then an aborted sync.
    sendByte(8'h00, 0); sendByte(8'h34, 0);
    sendMsg(16'd8, 16'h0A0B, 16'h0C0D, 1);
    sendByte(8'h34, 0); sendByte(8'h55, 0);
    idleCycles(2);

    // Illegal counts: below header size and above the maximum.
    sendByte(8'h34, 0); sendByte(8'h12, 0); sendByte(8'h04, 0); sendByte(8'h00, 0);
    idleCycles(1);
    sendMsg(MaxCnt + 16'd1, 16'h1111, 16'h2222, 0);
    idleCycles(2);
    chk("held_id", MsgID, 16'h0A0B);

    // Stall mid-header until the timeout fires, then a clean message.
    sendByte(8'h34, 0); sendByte(8'h12, 0); sendByte(8'h10, 0); sendByte(8'h00, 0);
    idleCycles(ToClk + 4);
    sendMsg(16'd10, 16'h3333, 16'h4444, 2);

    // Payload containing a sync pair is plain data.
    sendByte(8'h34, 0); sendByte(8'h12, 0); sendByte(8'h0C, 0); sendByte(8'h00, 0);
    sendByte(8'h01, 0); sendByte(8'h00, 0); sendByte(8'h02, 0); sendByte(8'h00, 0);
    sendByte(8'h34, 0); sendByte(8'h12, 0); sendByte(8'h34, 0); sendByte(8'h12, 0);
    idleCycles(2);

    // Reset in the middle of a payload.
    sendByte(8'h34, 0); sendByte(8'h12, 0); sendByte(8'h10, 0); sendByte(8'h00, 0);
    for (int i = 0; i < 6; i++) sendByte(8'(i), 0);
    step(1'b0, 1'b0, 8'h00);
    sendMsg(16'd9, 16'h5555, 16'h6666, 1);
    idleCycles(2);

    // Random mix of messages, garbage, bad counts and stalls.
    for (int m = 0; m < 40; m++) begin
      case ($urandom_range(5))
        0: for (int i = 0; i < 3; i++)
             sendByte(($urandom_range(1) == 0) ? 8'h34 : 8'($urandom), 1);
        1: sendMsg(16'($urandom_range(7)), 16'($urandom), 16'($urandom), 2);
        2: begin
             sendByte(8'h34, 1); sendByte(8'h12, 1);
             for (int i = 0; i < int'($urandom_range(5)); i++) sendByte(8'($urandom), 1);
             idleCycles(ToClk + 2);
           end
        default: sendMsg(16'(8 + $urandom_range(16)), 16'($urandom), 16'($urandom), 3);
      endcase
    end
    idleCycles(ToClk + 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
